// File: rtl/sipo_frame_pkg.sv
// Shared types for the framed SIPO receiver: FSM state encoding and a width helper.
package sipo_frame_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/sipo_frame_if.sv
// Parallel word output channel of the framed receiver (valid/ready handshake).
interface sipo_frame_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              ready;

    modport master (output data_out, output valid, input ready);
    modport slave  (input data_out, input valid, output ready);
endinterface

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register; MSB-first, advances only when shift_en is high.
module sipo_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              In,
    output logic [DATA_W-1:0] Q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            Q <= '0;
        end else if (shift_en) begin
            Q <= {Q[DATA_W-2:0], In};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: start bit, DATA_W payload bits MSB-first, optional parity, stop bit.
// Define SIPO_FRAME_PARITY_EN to add an even-parity bit before the stop bit and a parity_err port.
module sipo_frame_ctrl
    import sipo_frame_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         In,
    sipo_frame_if.master bus,
    output logic         busy,
    output logic         frame_err,
    output logic         overrun
`ifdef SIPO_FRAME_PARITY_EN
    ,
    output logic         parity_err
`endif
);

    localparam int               CNT_W    = clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [DATA_W-1:0] sreg;
    logic              shift_en;
    logic              stop_sample;
    logic              par_fail;
    logic              good;
    logic              accept;

    assign shift_en = en && (state == SHIFT);

    sipo_shift_reg #(.DATA_W(DATA_W)) u_sreg (
        .clk      (clk),
        .clr      (clr),
        .shift_en (shift_en),
        .In       (In),
        .Q        (sreg)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (en) begin
            case (state)
                IDLE: begin
                    if (!In) begin
                        state_next = SHIFT;
                        cnt_next   = '0;
                    end
                end
                SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        cnt_next = '0;
`ifdef SIPO_FRAME_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign stop_sample = en && (state == STOP);

`ifdef SIPO_FRAME_PARITY_EN
    // Remembers the parity verdict until the stop bit decides the word's fate.
    logic par_bad;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (en && (state == PARITY)) begin
                par_bad <= ^{sreg, In};
            end
            parity_err <= stop_sample && par_bad;
        end
    end

    assign par_fail = par_bad;
`else
    assign par_fail = 1'b0;
`endif

    assign good   = stop_sample && In && !par_fail;
    assign accept = bus.valid && bus.ready;

    // A word completing on the same edge as a handshake replaces the consumed one without overrun.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus.data_out <= '0;
            bus.valid    <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_err <= stop_sample && !In;
            if (good && (!bus.valid || accept)) begin
                bus.data_out <= sreg;
                bus.valid    <= 1'b1;
            end else if (accept) begin
                bus.valid <= 1'b0;
            end
            if (good && bus.valid && !accept) begin
                overrun <= 1'b1;
            end else if (accept) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl: directed frames queue expected words/error pulses, a monitor pops them.
module tb_sipo_frame_ctrl;

    localparam int K_WORD = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic clr;
    logic en;
    logic In;
    logic busy;
    logic frame_err;
    logic overrun;
`ifdef SIPO_FRAME_PARITY_EN
    logic parity_err;
`endif

    int   errors;
    int   checks;
    exp_t q[$];

    sipo_frame_if #(.DATA_W(8)) bus ();

    sipo_frame_ctrl #(.DATA_W(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .In        (In),
        .bus       (bus),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef SIPO_FRAME_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_out(input int kind, input logic [7:0] data);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: kind %0d data %0h, required nothing", kind, data);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.data !== data) begin
                errors++;
                $display("FAIL scoreboard: got kind %0d data %0h, required kind %0d data %0h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (clr) begin
            if (frame_err) expect_out(K_FERR, 8'h00);
`ifdef SIPO_FRAME_PARITY_EN
            if (parity_err) expect_out(K_PERR, 8'h00);
`endif
            if (bus.valid && bus.ready) expect_out(K_WORD, bus.data_out);
        end
    end

    task automatic push(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the edge that sampled the bit.
    task automatic send_bit(input logic b, input int gap);
        en = 1'b1;
        In = b;
        @(posedge clk);
        #1;
        en = 1'b0;
        for (int i = 0; i < gap; i++) begin
            In = ~In;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int gap,
                              input logic rdy_stop);
        send_bit(1'b0, gap);
        for (int i = 7; i >= 0; i--) send_bit(data[i], gap);
`ifdef SIPO_FRAME_PARITY_EN
        send_bit(^data, gap);
`endif
        if (rdy_stop) bus.ready = 1'b1;
        send_bit(stop, gap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk       = 1'b0;
        clr       = 1'b0;
        en        = 1'b0;
        In        = 1'b1;
        bus.ready = 1'b1;
        errors    = 0;
        checks    = 0;

        #2;
        chk("reset_valid", {31'd0, bus.valid}, 32'd0);
        chk("reset_data", {24'd0, bus.data_out}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;

        // Idle-level strobes must not start a frame
        send_bit(1'b1, 0);
        send_bit(1'b1, 1);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // 1: single frame, consumer ready
        push(K_WORD, 8'hA5);
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        @(negedge clk);
        chk("t1_valid", {31'd0, bus.valid}, 32'd1);
        chk("t1_data", {24'd0, bus.data_out}, 32'hA5);
        chk("t1_ferr", {31'd0, frame_err}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("t1_valid_drop", {31'd0, bus.valid}, 32'd0);
        @(posedge clk);
        #1;

        // 2: two frames while stalled -> overrun, second word dropped
        bus.ready = 1'b0;
        push(K_WORD, 8'h3C);
        send_frame(8'h3C, 1'b1, 0, 1'b0);
        send_frame(8'h81, 1'b1, 0, 1'b0);
        @(negedge clk);
        chk("t2_valid", {31'd0, bus.valid}, 32'd1);
        chk("t2_data", {24'd0, bus.data_out}, 32'h3C);
        chk("t2_overrun", {31'd0, overrun}, 32'd1);
        @(posedge clk);
        #1;
        bus.ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t2_valid_clr", {31'd0, bus.valid}, 32'd0);
        chk("t2_overrun_clr", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;

        // Handshake and new word on the same edge: replaced, no overrun
        bus.ready = 1'b0;
        push(K_WORD, 8'h11);
        send_frame(8'h11, 1'b1, 0, 1'b0);
        push(K_WORD, 8'h22);
        send_frame(8'h22, 1'b1, 0, 1'b1);
        @(negedge clk);
        chk("same_edge_valid", {31'd0, bus.valid}, 32'd1);
        chk("same_edge_data", {24'd0, bus.data_out}, 32'h22);
        chk("same_edge_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;

        // 3: bad stop bit
        push(K_FERR, 8'h00);
        send_frame(8'hFF, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("t3_ferr", {31'd0, frame_err}, 32'd1);
        chk("t3_valid", {31'd0, bus.valid}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_data_kept", {24'd0, bus.data_out}, 32'h22);
        @(negedge clk);
        chk("t3_ferr_pulse", {31'd0, frame_err}, 32'd0);
        @(posedge clk);
        #1;

        // 4: reset mid-frame
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        clr = 1'b0;
        #1;
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_data", {24'd0, bus.data_out}, 32'd0);
        chk("t4_valid", {31'd0, bus.valid}, 32'd0);
        chk("t4_ferr", {31'd0, frame_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        push(K_WORD, 8'h5A);
        send_frame(8'h5A, 1'b1, 0, 1'b0);
        @(negedge clk);
        chk("t4_after_data", {24'd0, bus.data_out}, 32'h5A);
        @(posedge clk);
        #1;

        // 5: sparse strobes with line toggling in between
        push(K_WORD, 8'hC3);
        send_frame(8'hC3, 1'b1, 2, 1'b0);
        @(negedge clk);
        chk("t5_data", {24'd0, bus.data_out}, 32'hC3);
        @(posedge clk);
        #1;

`ifdef SIPO_FRAME_PARITY_EN
        // 6: explicit parity bits
        push(K_WORD, 8'hA5);
        send_bit(1'b0, 0);
        for (int i = 7; i >= 0; i--) send_bit(8'hA5 >> i, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        @(negedge clk);
        chk("t6_good_perr", {31'd0, parity_err}, 32'd0);
        @(posedge clk);
        #1;
        push(K_PERR, 8'h00);
        send_bit(1'b0, 0);
        for (int i = 7; i >= 0; i--) send_bit(8'hA5 >> i, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        @(negedge clk);
        chk("t6_perr", {31'd0, parity_err}, 32'd1);
        chk("t6_valid", {31'd0, bus.valid}, 32'd0);
        @(posedge clk);
        #1;
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
